// File: rtl/ascon_pkg.sv
// Shared types and helpers for the Ascon rate-block padder.
package ascon_pkg;

  typedef logic [7:0] axi_tuser_t;

  localparam logic [7:0] ASCON_PAD_BYTE = 8'h01;

  typedef enum logic {
    ST_PASS  = 1'b0,
    ST_EXTRA = 1'b1
  } pad_state_e;

  // Number of valid bytes in a beat (0..8).
  function automatic logic [3:0] tkeep_to_count(input logic [7:0] keep);
    logic [3:0] cnt;
    cnt = 4'd0;
    for (int i = 0; i < 8; i++) begin
      cnt = cnt + {3'b000, keep[i]};
    end
    return cnt;
  endfunction

endpackage

// File: rtl/ascon_padder.sv
// Ascon 10* padder: turns an AXI4-Stream byte message into 64-bit rate blocks.
// Optional tkeep checking is enabled with ASCON_PADDER_TKEEP_CHECK_EN.
module ascon_padder
  import ascon_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic [63:0] s_axis_tdata_i,
  input  logic [7:0]  s_axis_tkeep_i,
  input  axi_tuser_t  s_axis_tuser_i,
  input  logic        s_axis_tlast_i,
  input  logic        s_axis_tvalid_i,
  output logic        s_axis_tready_o,
  output logic [63:0] m_axis_tdata_o,
  output axi_tuser_t  m_axis_tuser_o,
  output logic        m_axis_tlast_o,
  output logic        m_axis_tvalid_o,
  input  logic        m_axis_tready_i,
  output logic        pad_err_o
);

  pad_state_e  r_state, w_state_nxt;
  logic [63:0] r_tdata, w_tdata_nxt;
  axi_tuser_t  r_tuser, w_tuser_nxt;
  logic        r_tlast, w_tlast_nxt;
  logic        r_tvalid, w_tvalid_nxt;

  logic        w_out_free;
  logic        w_accept;
  logic [3:0]  w_n;
  logic [63:0] w_padded;

  assign w_out_free      = !r_tvalid || m_axis_tready_i;
  assign s_axis_tready_o = !rst && (r_state == ST_PASS) && w_out_free;
  assign w_accept        = s_axis_tvalid_i && s_axis_tready_o;

  // Build the padded last block: kept bytes, then the pad byte, then zeros.
  always_comb begin
    w_n      = tkeep_to_count(s_axis_tkeep_i);
    w_padded = 64'd0;
    for (int i = 0; i < 8; i++) begin
      if ((4'(i) < w_n) && s_axis_tkeep_i[i]) begin
        w_padded[8*i +: 8] = s_axis_tdata_i[8*i +: 8];
      end else if (4'(i) == w_n) begin
        w_padded[8*i +: 8] = ASCON_PAD_BYTE;
      end else begin
        w_padded[8*i +: 8] = 8'h00;
      end
    end
  end

  always_comb begin
    w_state_nxt  = r_state;
    w_tdata_nxt  = r_tdata;
    w_tuser_nxt  = r_tuser;
    w_tlast_nxt  = r_tlast;
    w_tvalid_nxt = r_tvalid && !m_axis_tready_i;
    case (r_state)
      ST_PASS: begin
        if (w_accept) begin
          w_tvalid_nxt = 1'b1;
          w_tuser_nxt  = s_axis_tuser_i;
          w_tdata_nxt  = s_axis_tlast_i ? w_padded : s_axis_tdata_i;
          // A full last beat leaves no room for padding: emit it, then an extra block.
          w_tlast_nxt  = s_axis_tlast_i && (w_n != 4'd8);
          if (s_axis_tlast_i && (w_n == 4'd8)) begin
            w_state_nxt = ST_EXTRA;
          end else begin
            w_state_nxt = ST_PASS;
          end
        end else begin
          w_state_nxt = ST_PASS;
        end
      end
      ST_EXTRA: begin
        // tuser is left untouched so the extra block carries the last beat's sideband.
        if (w_out_free) begin
          w_tvalid_nxt = 1'b1;
          w_tdata_nxt  = {56'd0, ASCON_PAD_BYTE};
          w_tlast_nxt  = 1'b1;
          w_state_nxt  = ST_PASS;
        end else begin
          w_state_nxt = ST_EXTRA;
        end
      end
      default: begin
        w_state_nxt = ST_PASS;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state  <= ST_PASS;
      r_tdata  <= 64'd0;
      r_tuser  <= '0;
      r_tlast  <= 1'b0;
      r_tvalid <= 1'b0;
    end else begin
      r_state  <= w_state_nxt;
      r_tdata  <= w_tdata_nxt;
      r_tuser  <= w_tuser_nxt;
      r_tlast  <= w_tlast_nxt;
      r_tvalid <= w_tvalid_nxt;
    end
  end

  assign m_axis_tdata_o  = r_tdata;
  assign m_axis_tuser_o  = r_tuser;
  assign m_axis_tlast_o  = r_tlast;
  assign m_axis_tvalid_o = r_tvalid;

`ifdef ASCON_PADDER_TKEEP_CHECK_EN
  logic r_pad_err;
  logic w_keep_bad;

  // A contiguous-from-LSB mask plus one has no bits in common with the mask.
  assign w_keep_bad = ((s_axis_tkeep_i & (s_axis_tkeep_i + 8'd1)) != 8'd0) ||
                      (!s_axis_tlast_i && (s_axis_tkeep_i != 8'hFF));

  always_ff @(posedge clk) begin
    if (rst) begin
      r_pad_err <= 1'b0;
    end else if (w_accept && w_keep_bad) begin
      r_pad_err <= 1'b1;
    end else begin
      r_pad_err <= r_pad_err;
    end
  end

  assign pad_err_o = r_pad_err;
`else
  assign pad_err_o = 1'b0;
`endif

endmodule

// File: tb/tb_ascon_padder.sv
// Self-checking bench for ascon_padder: directed cases plus randomized messages
// checked against a byte-level padding model and a block queue.
module tb_ascon_padder;
  import ascon_pkg::*;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [63:0] in_data = 64'd0;
  logic [7:0]  in_keep = 8'd0;
  axi_tuser_t  in_user = '0;
  logic        in_last = 1'b0;
  logic        in_valid = 1'b0;
  logic        s_ready;
  logic [63:0] m_data;
  axi_tuser_t  m_user;
  logic        m_last;
  logic        m_valid;
  logic        out_ready = 1'b0;
  logic        pad_err;

  ascon_padder dut (
    .clk             (clk),
    .rst             (rst),
    .s_axis_tdata_i  (in_data),
    .s_axis_tkeep_i  (in_keep),
    .s_axis_tuser_i  (in_user),
    .s_axis_tlast_i  (in_last),
    .s_axis_tvalid_i (in_valid),
    .s_axis_tready_o (s_ready),
    .m_axis_tdata_o  (m_data),
    .m_axis_tuser_o  (m_user),
    .m_axis_tlast_o  (m_last),
    .m_axis_tvalid_o (m_valid),
    .m_axis_tready_i (out_ready),
    .pad_err_o       (pad_err)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  logic [63:0] exp_d[$];
  logic [7:0]  exp_u[$];
  logic        exp_l[$];

  bit          rand_ready = 1'b0;
  bit          hold_pending = 1'b0;
  logic [63:0] hold_d;
  logic [7:0]  hold_u;
  logic        hold_l;
  logic [63:0] last_out_d = 64'd0;
  logic        last_out_l = 1'b0;
  int          win_cnt = 0;
  int          win_first = 0;
  int          win_last = 0;
  int          rdy_low = 0;
  int          valid_seen = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Reference: the message bytes, then 0x01, then zeros; a full last beat spills the pad into a new block.
  task automatic model_beat(input logic [63:0] d, input logic [7:0] k, input logic l, input logic [7:0] u);
    int n;
    logic [7:0] bytes [8];
    logic [63:0] blk;
    if (!l) begin
      exp_d.push_back(d); exp_u.push_back(u); exp_l.push_back(1'b0);
    end else begin
      n = $countones(k);
      for (int i = 0; i < 8; i++) begin
        if (i < n) bytes[i] = d[8*i +: 8];
        else if (i == n) bytes[i] = 8'h01;
        else bytes[i] = 8'h00;
        blk[8*i +: 8] = bytes[i];
      end
      if (n == 8) begin
        exp_d.push_back(blk); exp_u.push_back(u); exp_l.push_back(1'b0);
        exp_d.push_back(64'h1); exp_u.push_back(u); exp_l.push_back(1'b1);
      end else begin
        exp_d.push_back(blk); exp_u.push_back(u); exp_l.push_back(1'b1);
      end
    end
  endtask

  task automatic cycle(output bit acc);
    if (rand_ready) out_ready = 1'($urandom_range(0, 1));
    @(negedge clk);
    if (hold_pending) begin
      check("stall_valid", {63'd0, m_valid}, 64'd1);
      check("stall_data", m_data, hold_d);
      check("stall_user", {56'd0, m_user}, {56'd0, hold_u});
      check("stall_last", {63'd0, m_last}, {63'd0, hold_l});
    end
    hold_pending = m_valid && !out_ready;
    hold_d = m_data; hold_u = m_user; hold_l = m_last;
    if (!s_ready) rdy_low++;
    if (m_valid) valid_seen++;
    if (m_valid && out_ready) begin
      if (exp_d.size() == 0) begin
        check("spurious_block", m_data, 64'hX);
      end else begin
        check("out_data", m_data, exp_d.pop_front());
        check("out_user", {56'd0, m_user}, {56'd0, exp_u.pop_front()});
        check("out_last", {63'd0, m_last}, {63'd0, exp_l.pop_front()});
      end
      last_out_d = m_data;
      last_out_l = m_last;
      if (win_cnt == 0) win_first = cyc;
      win_last = cyc;
      win_cnt++;
    end
    acc = in_valid && s_ready;
    if (acc) model_beat(in_data, in_keep, in_last, in_user);
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic send_beat(input logic [63:0] d, input logic [7:0] k, input logic l, input logic [7:0] u);
    bit done;
    done = 1'b0;
    in_data = d; in_keep = k; in_last = l; in_user = u; in_valid = 1'b1;
    for (int t = 0; t < 1000 && !done; t++) cycle(done);
    if (!done) check("accept_timeout", 64'd0, 64'd1);
  endtask

  task automatic drain();
    bit a;
    in_valid = 1'b0;
    for (int t = 0; t < 1000 && (exp_d.size() != 0 || m_valid); t++) cycle(a);
    check("drain_empty", 64'(exp_d.size()), 64'd0);
  endtask

  task automatic idle(input int n);
    bit a;
    in_valid = 1'b0;
    for (int t = 0; t < n; t++) cycle(a);
  endtask

  initial begin
    logic [63:0] d;
    int n;
    int beats;

    // Reset values while rst is held
    repeat (3) @(posedge clk);
    in_valid = 1'b1;
    @(negedge clk);
    check("rst_tvalid", {63'd0, m_valid}, 64'd0);
    check("rst_tlast", {63'd0, m_last}, 64'd0);
    check("rst_tdata", m_data, 64'd0);
    check("rst_tuser", {56'd0, m_user}, 64'd0);
    check("rst_pad_err", {63'd0, pad_err}, 64'd0);
    check("rst_tready", {63'd0, s_ready}, 64'd0);
    @(posedge clk); #1;
    in_valid = 1'b0;
    rst = 1'b0;
    out_ready = 1'b1;

    // Three-byte message, with junk in the unkept bytes
    send_beat(64'hDEAD_BEEF_55CC_BBAA, 8'h07, 1'b1, 8'h11);
    drain();
    check("msg3_data", last_out_d, 64'h0000_0000_01CC_BBAA);
    check("msg3_last", {63'd0, last_out_l}, 64'd1);

    // Eight-byte message: data block, then extra pad block, one stall cycle on input
    win_cnt = 0;
    send_beat(64'h0807_0605_0403_0201, 8'hFF, 1'b1, 8'h22);
    rdy_low = 0;
    drain();
    idle(3);
    check("msg8_tready_low", 64'(rdy_low), 64'd1);
    check("msg8_blocks", 64'(win_cnt), 64'd2);
    check("msg8_extra_data", last_out_d, 64'h1);
    check("msg8_extra_last", {63'd0, last_out_l}, 64'd1);

    // Empty message
    send_beat(64'hFFFF_FFFF_FFFF_FFFF, 8'h00, 1'b1, 8'h33);
    drain();
    check("empty_data", last_out_d, 64'h1);
    check("empty_last", {63'd0, last_out_l}, 64'd1);

    // Ten beats back to back with downstream always ready
    win_cnt = 0;
    for (int i = 0; i < 10; i++) begin
      d = {$urandom, $urandom};
      send_beat(d, (i == 9) ? 8'h1F : 8'hFF, (i == 9), 8'(i));
    end
    drain();
    check("burst_count", 64'(win_cnt), 64'd10);
    check("burst_span", 64'(win_last - win_first), 64'd9);

    // Random messages with random downstream back-pressure
    rand_ready = 1'b1;
    for (int m = 0; m < 40; m++) begin
      beats = $urandom_range(1, 4);
      for (int b = 0; b < beats; b++) begin
        d = {$urandom, $urandom};
        if (b == beats - 1) begin
          n = $urandom_range(0, 8);
          send_beat(d, 8'((16'd1 << n) - 16'd1), 1'b1, 8'($urandom));
        end else begin
          send_beat(d, 8'hFF, 1'b0, 8'($urandom));
        end
      end
      if ($urandom_range(0, 3) == 0) idle($urandom_range(1, 3));
    end
    drain();
    rand_ready = 1'b0;
    out_ready = 1'b1;

    // Reset while the extra block is still pending
    out_ready = 1'b0;
    send_beat(64'h1122_3344_5566_7788, 8'hFF, 1'b1, 8'h44);
    in_valid = 1'b0;
    idle(2);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    exp_d.delete(); exp_u.delete(); exp_l.delete();
    hold_pending = 1'b0;
    check("rst_extra_tvalid", {63'd0, m_valid}, 64'd0);
    out_ready = 1'b1;
    valid_seen = 0;
    idle(6);
    check("rst_extra_no_block", 64'(valid_seen), 64'd0);
    send_beat(64'h0000_0000_0000_00A5, 8'h01, 1'b1, 8'h55);
    drain();
    check("post_rst_msg", last_out_d, 64'h0000_0000_0000_01A5);

    // Bad tkeep on a non-last beat
    check("pad_err_before", {63'd0, pad_err}, 64'd0);
    send_beat(64'h0102_0304_0506_0708, 8'h0F, 1'b0, 8'h66);
    send_beat(64'h0, 8'h00, 1'b1, 8'h66);
    in_valid = 1'b0;
`ifdef ASCON_PADDER_TKEEP_CHECK_EN
    check("pad_err_set", {63'd0, pad_err}, 64'd1);
    drain();
    idle(4);
    check("pad_err_sticky", {63'd0, pad_err}, 64'd1);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    check("pad_err_cleared", {63'd0, pad_err}, 64'd0);
`else
    check("pad_err_tied", {63'd0, pad_err}, 64'd0);
    drain();
    idle(4);
    check("pad_err_still_tied", {63'd0, pad_err}, 64'd0);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
